jtframe_sdram_bank_mux: RTL
===========================

# jtframe_sdram_bank_mux

Four-client front end for `jtframe_sdram_bank_core`: it is the request-issuing side of the core's rd/wr/ack/rdy handshake, i.e. the RTL equivalent of what the bank-core bench drives. Client k owns SDRAM bank k. The block arbitrates the four clients round-robin, presents one request at a time to the core, and routes completions back by `ba_rdy`. Returned data is latched per client. It sits between game-side ROM/RAM clients and the bank core.

## Interface
Parameters:
- `AW`, 22: client address width (≤23); zero-extended onto the core's 23-bit `addr`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `slot_addr`  in  4*AW  client k address at bits [k*AW +: AW]
- `slot_rd`  in  4  read request, level, held until `slot_ok`
- `slot_wr`  in  4  write request, level, held until `slot_ok`; rd wins if both are set
- `slot_din`  in  4*16  write data
- `slot_din_m`  in  4*2  write byte mask, passed to `din_m`
- `slot_ok`  out  4  request complete, high until the client drops its request
- `slot_dout`  out  4*32  last read data per client
- `addr`  out  23  to core
- `rd`, `wr`  out  1  to core
- `ba_rq`  out  2  to core, equals the granted client index
- `din`  out  16  to core
- `din_m`  out  2  to core
- `rfsh_en`  out  1  to core
- `ack`  in  1  from core
- `rdy`  in  1  from core
- `ba_rdy`  in  2  from core
- `dout`  in  32  from core

## Operation
Each slot runs its own FSM with four states:
- `IDLE`
  - goes to `PEND` when a request is asserted.
- `PEND`
  - goes to `WAIT` on a core `ack` while granted.
- `WAIT`
  - goes to `DONE` on `rdy` with `ba_rdy`==k.
  - If the client has already dropped its request, goes to `IDLE` instead; the data is discarded and `slot_ok` is not raised.
- `DONE`
  - `slot_ok`=1.
  - Goes to `IDLE` the cycle after both `slot_rd` and `slot_wr` are low.

Arbitration:
- A single grant register holds the active slot plus a valid bit.
- When there is no valid grant, or on an `ack` cycle, the next grant is taken from slots in `PEND`. Search order starts at the last granted index +1 and wraps 3→0.
- Core outputs are registered from the grant: `rd`/`wr` per request type, `addr`, `ba_rq`, `din`, `din_m`.
- On the `ack` edge the outputs switch to the next grant if one exists, otherwise to `rd`=`wr`=0. Back-to-back grants have no idle cycle.
- A slot dropping its request while in `PEND` is released: its grant is kept until `ack`, then the result is discarded as above.

Completion:
- On `rdy`, `dout` is written into `slot_dout[ba_rdy]` only if that slot is in `WAIT` and the request is still held.
- `rdy` for a slot not in `WAIT` is ignored.
- Writes complete through `rdy` in the same way, and `slot_dout` is left unchanged.

Refresh:
- `rfsh_en` = 1 when there is no valid grant and no slot is in `PEND`.

## Timing
Reset values:
- All FSMs `IDLE`.
- `rd`=`wr`=0, `addr`/`ba_rq`/`din`/`din_m`=0.
- `rfsh_en`=1, `slot_ok`=0, `slot_dout`=0.
- Round-robin pointer = 3, so slot 0 has first priority.

Latency and concurrency:
- Request seen at edge n → `rd`/`wr` high after edge n+1, provided no grant is active.
- Total latency = 1 + core ack latency + core data latency; `slot_ok` rises the edge after `rdy`.
- `ack` and `rdy` in the same cycle for different slots are both processed.
- Up to four slots may be in `WAIT` at once.

Reset mid-operation clears all state. A core `rdy` arriving after reset release finds no slot in `WAIT` and is ignored.

## Structure
Package `jtframe_sdram_bank_mux_pkg`:
- slot-state enum {IDLE, PEND, WAIT, DONE}
- `NSLOT`=4
- `CORE_AW`=23

Sub-module `jtframe_sdram_bank_slot`: one per-slot FSM plus its data latch, instantiated four times. The top level holds the arbiter, the grant register and the core-side output registers.

## Test plan
Use a behavioral core model with configurable `ack`/`rdy` delays.
1. Slot 0 reads `addr`=0x1234 with ack after 2 cycles and rdy after 5 with `dout`=0xDEADBEEF → `ba_rq`=0 and `addr`=0x001234; `slot_ok[0]` rises; `slot_dout[0]`=0xDEADBEEF; ok clears 1 cycle after `slot_rd[0]` drops.
2. All four slots request in the same cycle → grants issued in order 0,1,2,3 with `rd` held high continuously. Then slot 1 and slot 3 re-request together while the pointer is at 3 → slot 1 is granted first.
3. Slot 2 writes `din`=0xA55A, `din_m`=2'b01 → `wr`=1, `din`/`din_m` match, `slot_ok[2]` rises on rdy, `slot_dout[2]` unchanged.
4. Core returns rdy out of order: bank 3 before bank 1, plus `ack` (slot 2) and `rdy` (slot 1) in the same cycle → each `slot_dout` holds its own data and no completion is lost.
5. Slot 1 drops `slot_rd` while in `WAIT` → its rdy is discarded, `slot_ok[1]` stays 0 and `slot_dout[1]` is unchanged.
6. Assert `rst_n`=0 while slots 0 and 2 are in `WAIT`, then deliver rdy for both after release → all outputs stay at reset values and `rfsh_en`=1.

Source files
------------

// File: rtl/jtframe_sdram_bank_mux_pkg.sv
// Shared types and constants for the four-client SDRAM bank front end.
package jtframe_sdram_bank_mux_pkg;
    localparam int NSLOT   = 4;
    localparam int CORE_AW = 23;

    typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} slot_st_t;
endpackage

// File: rtl/jtframe_sdram_bank_slot.sv
// Per-client request tracker: request FSM plus the latch for returned read data.
module jtframe_sdram_bank_slot
    import jtframe_sdram_bank_mux_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_granted,
    input  logic        i_ack,
    input  logic        i_core_wr,
    input  logic        i_rdy,
    input  logic [31:0] i_dout,
    output slot_st_t    o_st,
    output logic        o_ok,
    output logic [31:0] o_dout
);
    slot_st_t    r_st, w_nxt;
    logic        r_is_wr;
    logic [31:0] r_dout;
    logic        w_req;

    assign w_req  = i_rd | i_wr;
    assign o_st   = r_st;
    assign o_ok   = (r_st == DONE);
    assign o_dout = r_dout;

    always_comb begin
        w_nxt = r_st;
        case (r_st)
            IDLE: if (w_req) w_nxt = PEND;
            // An ungranted slot that gives up can leave; a granted one must see its ack
            PEND: if (i_ack) w_nxt = WAIT;
                  else if (!w_req && !i_granted) w_nxt = IDLE;
            WAIT: if (i_rdy) w_nxt = w_req ? DONE : IDLE;
            DONE: if (!w_req) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st    <= IDLE;
            r_is_wr <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_st <= w_nxt;
            if (i_ack) r_is_wr <= i_core_wr;
            if (r_st == WAIT && i_rdy && w_req && !r_is_wr) r_dout <= i_dout;
        end
    end
endmodule

// File: rtl/jtframe_sdram_bank_mux.sv
// Round-robin front end issuing one request at a time to the SDRAM bank core;
// client k owns bank k and completions are routed back by ba_rdy.
module jtframe_sdram_bank_mux
    import jtframe_sdram_bank_mux_pkg::*;
#(
    parameter int AW = 22
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*AW-1:0]       slot_addr,
    input  logic [3:0]            slot_rd,
    input  logic [3:0]            slot_wr,
    input  logic [4*16-1:0]       slot_din,
    input  logic [4*2-1:0]        slot_din_m,
    output logic [3:0]            slot_ok,
    output logic [4*32-1:0]       slot_dout,
    output logic [CORE_AW-1:0]    addr,
    output logic                  rd,
    output logic                  wr,
    output logic [1:0]            ba_rq,
    output logic [15:0]           din,
    output logic [1:0]            din_m,
    output logic                  rfsh_en,
    input  logic                  ack,
    input  logic                  rdy,
    input  logic [1:0]            ba_rdy,
    input  logic [31:0]           dout
);
    slot_st_t         w_st [NSLOT];
    logic [AW-1:0]    w_addr [NSLOT];
    logic [15:0]      w_din [NSLOT];
    logic [1:0]       w_din_m [NSLOT];
    logic [NSLOT-1:0] w_pend, w_cand, w_gnt;

    logic             r_gnt_vld;
    logic [1:0]       r_gnt_idx, r_ptr;
    logic             r_rd, r_wr;
    logic [CORE_AW-1:0] r_addr;
    logic [15:0]      r_din;
    logic [1:0]       r_din_m;

    logic             w_ack, w_take, w_found;
    logic [1:0]       w_next, w_idx;

    assign w_ack  = ack & r_gnt_vld;
    assign w_take = ~r_gnt_vld | w_ack;

    generate
        for (genvar k = 0; k < NSLOT; k++) begin : g_slot
            assign w_addr[k]  = slot_addr[k*AW +: AW];
            assign w_din[k]   = slot_din[k*16 +: 16];
            assign w_din_m[k] = slot_din_m[k*2 +: 2];
            assign w_gnt[k]   = r_gnt_vld && (r_gnt_idx == 2'(k));
            assign w_pend[k]  = (w_st[k] == PEND);
            // The slot already on the core bus is never a candidate, even on its ack cycle
            assign w_cand[k]  = w_pend[k] & (slot_rd[k] | slot_wr[k]) & ~w_gnt[k];

            jtframe_sdram_bank_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_rd      (slot_rd[k]),
                .i_wr      (slot_wr[k]),
                .i_granted (w_gnt[k]),
                .i_ack     (w_ack & w_gnt[k]),
                .i_core_wr (r_wr),
                .i_rdy     (rdy && (ba_rdy == 2'(k))),
                .i_dout    (dout),
                .o_st      (w_st[k]),
                .o_ok      (slot_ok[k]),
                .o_dout    (slot_dout[k*32 +: 32])
            );
        end
    endgenerate

    // Search starts one past the last grant and wraps
    always_comb begin
        w_found = 1'b0;
        w_next  = r_ptr;
        w_idx   = r_ptr;
        for (int i = 1; i <= NSLOT; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_vld <= 1'b0;
            r_gnt_idx <= 2'd0;
            r_ptr     <= 2'd3;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_din_m   <= '0;
        end else if (w_take) begin
            if (w_found) begin
                r_gnt_vld <= 1'b1;
                r_gnt_idx <= w_next;
                r_ptr     <= w_next;
                r_rd      <= slot_rd[w_next];
                r_wr      <= ~slot_rd[w_next] & slot_wr[w_next];
                r_addr    <= CORE_AW'(w_addr[w_next]);
                r_din     <= w_din[w_next];
                r_din_m   <= w_din_m[w_next];
            end else begin
                r_gnt_vld <= 1'b0;
                r_rd      <= 1'b0;
                r_wr      <= 1'b0;
            end
        end
    end

    assign rd      = r_rd;
    assign wr      = r_wr;
    assign addr    = r_addr;
    assign ba_rq   = r_gnt_idx;
    assign din     = r_din;
    assign din_m   = r_din_m;
    assign rfsh_en = ~r_gnt_vld & ~(|w_pend);
endmodule
